// File: rtl/klavye_kodlayici_if.sv
// -----------------------------------------------------------------------------
// klavye_kodlayici_if
//
// Bundles the character handshake, the lock-state feedback and the scan-code
// buses of the ASCII-to-scan-code transmitter.
//
//   master : character source / keyboard-controller side (drives the ASCII
//            handshake and the lock states, observes the scan-code buses)
//   slave  : klavye_kodlayici itself
//
// Signals
//   ascii_aktif    ascii_giris valid
//   ascii_giris    ASCII character (8 bits)
//   hazir          ready; transfer when ascii_aktif && hazir at a clock edge
//   caps_lock      caps lock state fed back from the controller
//   num_lock       num lock state fed back from the controller
//   buton_aktif    button code valid
//   buton_giris    button scan code (8 bits)
//   kontrol_aktif  control code valid
//   kontrol_giris  control scan code (0x12 = left shift)
//   hata           one-cycle pulse: unsupported character was dropped
// -----------------------------------------------------------------------------
interface klavye_kodlayici_if;
   logic       ascii_aktif;
   logic [7:0] ascii_giris;
   logic       hazir;
   logic       caps_lock;
   logic       num_lock;
   logic       buton_aktif;
   logic [7:0] buton_giris;
   logic       kontrol_aktif;
   logic [7:0] kontrol_giris;
   logic       hata;

   modport master (
      output ascii_aktif, ascii_giris, caps_lock, num_lock,
      input  hazir, buton_aktif, buton_giris, kontrol_aktif, kontrol_giris, hata
   );

   modport slave (
      input  ascii_aktif, ascii_giris, caps_lock, num_lock,
      output hazir, buton_aktif, buton_giris, kontrol_aktif, kontrol_giris, hata
   );
endinterface

// File: rtl/klavye_kodlayici.sv
// -----------------------------------------------------------------------------
// klavye_kodlayici
//
// ASCII-to-scan-code transmitter. Accepts one ASCII character per valid/ready
// handshake and replays it as a PS/2 set-2 key press on the button bus, with
// left shift (0x12) on the control bus whenever the character's case and the
// caps_lock state call for it. Each press holds the codes for BASMA_SURE
// cycles, followed by BOSLUK_SURE idle cycles.
//
// Parameters
//   BASMA_SURE   cycles the codes are held active per press (1..255)
//   BOSLUK_SURE  idle cycles after each press (0..255)
//
// Ports
//   clk    system clock, rising edge
//   rst_n  synchronous reset, active-low
//   bus    klavye_kodlayici_if.slave: ASCII handshake (ascii_aktif,
//          ascii_giris, hazir), lock feedback (caps_lock, num_lock),
//          scan-code outputs (buton_*, kontrol_*) and the hata pulse
//
// Optional feature
//   KLAVYE_NUMPAD_EN  when defined, digits accepted with num_lock=1 are sent
//                     as keypad codes; otherwise digits always use the main
//                     row and num_lock is not used.
// -----------------------------------------------------------------------------
module klavye_kodlayici #(
   parameter int unsigned BASMA_SURE  = 1,
   parameter int unsigned BOSLUK_SURE = 1
) (
   input  logic                  clk,
   input  logic                  rst_n,
   klavye_kodlayici_if.slave     bus
);

   localparam logic [7:0] SHIFT_KODU = 8'h12;
   localparam logic [7:0] BASMA_SON  = 8'(BASMA_SURE - 1);
   // Only meaningful when BOSLUK_SURE > 0; BIRAK is never entered otherwise.
   localparam logic [7:0] BOSLUK_SON = 8'(BOSLUK_SURE - 1);

   typedef enum logic [1:0] {
      BOS   = 2'd0,
      BAS   = 2'd1,
      BIRAK = 2'd2
   } durum_t;

   durum_t     durum, durum_d;
   logic [7:0] sayac, sayac_d;
   logic       hata_p1, hata_d;
   logic       kaydet;

   // Lookup result for the character currently on ascii_giris
   logic       gecerli;
   logic       kaydir;
   logic [7:0] kod;

   // Registered press contents
   logic [7:0] kod_p1;
   logic       kaydir_p1;

   // ---------------------------------------------------------------------------
   // Scan-code tables
   // ---------------------------------------------------------------------------
   function automatic logic [7:0] harf_kodu(input logic [4:0] i);
      logic [7:0] k;
      case (i)
         5'd0:    k = 8'h1C;   // A
         5'd1:    k = 8'h32;   // B
         5'd2:    k = 8'h21;   // C
         5'd3:    k = 8'h23;   // D
         5'd4:    k = 8'h24;   // E
         5'd5:    k = 8'h2B;   // F
         5'd6:    k = 8'h34;   // G
         5'd7:    k = 8'h33;   // H
         5'd8:    k = 8'h43;   // I
         5'd9:    k = 8'h3B;   // J
         5'd10:   k = 8'h42;   // K
         5'd11:   k = 8'h4B;   // L
         5'd12:   k = 8'h3A;   // M
         5'd13:   k = 8'h31;   // N
         5'd14:   k = 8'h44;   // O
         5'd15:   k = 8'h4D;   // P
         5'd16:   k = 8'h15;   // Q
         5'd17:   k = 8'h2D;   // R
         5'd18:   k = 8'h1B;   // S
         5'd19:   k = 8'h2C;   // T
         5'd20:   k = 8'h3C;   // U
         5'd21:   k = 8'h2A;   // V
         5'd22:   k = 8'h1D;   // W
         5'd23:   k = 8'h22;   // X
         5'd24:   k = 8'h35;   // Y
         5'd25:   k = 8'h1A;   // Z
         default: k = 8'h00;
      endcase
      return k;
   endfunction

   function automatic logic [7:0] rakam_kodu(input logic [3:0] i);
      logic [7:0] k;
      case (i)
         4'd0:    k = 8'h45;
         4'd1:    k = 8'h16;
         4'd2:    k = 8'h1E;
         4'd3:    k = 8'h26;
         4'd4:    k = 8'h25;
         4'd5:    k = 8'h2E;
         4'd6:    k = 8'h36;
         4'd7:    k = 8'h3D;
         4'd8:    k = 8'h3E;
         4'd9:    k = 8'h46;
         default: k = 8'h00;
      endcase
      return k;
   endfunction

`ifdef KLAVYE_NUMPAD_EN
   function automatic logic [7:0] tus_takimi_kodu(input logic [3:0] i);
      logic [7:0] k;
      case (i)
         4'd0:    k = 8'h70;
         4'd1:    k = 8'h69;
         4'd2:    k = 8'h72;
         4'd3:    k = 8'h7A;
         4'd4:    k = 8'h6B;
         4'd5:    k = 8'h73;
         4'd6:    k = 8'h74;
         4'd7:    k = 8'h6C;
         4'd8:    k = 8'h75;
         4'd9:    k = 8'h7D;
         default: k = 8'h00;
      endcase
      return k;
   endfunction
`endif

   // ---------------------------------------------------------------------------
   // Character lookup (combinational, consumed only at the handshake edge)
   // ---------------------------------------------------------------------------
   always_comb begin
      gecerli = 1'b0;
      kaydir  = 1'b0;
      kod     = 8'h00;
      if (bus.ascii_giris >= 8'h41 && bus.ascii_giris <= 8'h5A) begin
         // Uppercase needs shift unless caps lock already provides it.
         gecerli = 1'b1;
         kod     = harf_kodu(5'(bus.ascii_giris - 8'h41));
         kaydir  = ~bus.caps_lock;
      end else if (bus.ascii_giris >= 8'h61 && bus.ascii_giris <= 8'h7A) begin
         // Lowercase needs shift only to cancel an active caps lock.
         gecerli = 1'b1;
         kod     = harf_kodu(5'(bus.ascii_giris - 8'h61));
         kaydir  = bus.caps_lock;
      end else if (bus.ascii_giris >= 8'h30 && bus.ascii_giris <= 8'h39) begin
         gecerli = 1'b1;
`ifdef KLAVYE_NUMPAD_EN
         if (bus.num_lock)
            kod = tus_takimi_kodu(4'(bus.ascii_giris - 8'h30));
         else
            kod = rakam_kodu(4'(bus.ascii_giris - 8'h30));
`else
         kod = rakam_kodu(4'(bus.ascii_giris - 8'h30));
`endif
      end else begin
         case (bus.ascii_giris)
            8'h20: begin gecerli = 1'b1; kod = 8'h29; end   // space
            8'h0D: begin gecerli = 1'b1; kod = 8'h5A; end   // enter
            8'h09: begin gecerli = 1'b1; kod = 8'h0D; end   // tab
            8'h3B: begin gecerli = 1'b1; kod = 8'h4C; end   // ';'
            default: ;
         endcase
      end
   end

   // ---------------------------------------------------------------------------
   // FSM next state, counter and load strobe
   // ---------------------------------------------------------------------------
   always_comb begin
      durum_d = durum;
      sayac_d = sayac;
      kaydet  = 1'b0;
      hata_d  = 1'b0;
      case (durum)
         BOS: begin
            if (bus.ascii_aktif) begin
               if (gecerli) begin
                  kaydet  = 1'b1;
                  sayac_d = 8'h00;
                  durum_d = BAS;
               end else begin
                  hata_d = 1'b1;
               end
            end
         end
         BAS: begin
            if (sayac == BASMA_SON) begin
               sayac_d = 8'h00;
               if (BOSLUK_SURE == 0)
                  durum_d = BOS;
               else
                  durum_d = BIRAK;
            end else begin
               sayac_d = sayac + 8'h01;
            end
         end
         BIRAK: begin
            if (sayac == BOSLUK_SON) begin
               sayac_d = 8'h00;
               durum_d = BOS;
            end else begin
               sayac_d = sayac + 8'h01;
            end
         end
         default: begin
            sayac_d = 8'h00;
            durum_d = BOS;
         end
      endcase
   end

   // ---------------------------------------------------------------------------
   // Stage p1: control state
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         durum   <= BOS;
         sayac   <= 8'h00;
         hata_p1 <= 1'b0;
      end else begin
         durum   <= durum_d;
         sayac   <= sayac_d;
         hata_p1 <= hata_d;
      end
   end

   // Press contents need no reset: they only reach the outputs while in BAS.
   always_ff @(posedge clk) begin
      if (kaydet) begin
         kod_p1    <= kod;
         kaydir_p1 <= kaydir;
      end
   end

   // ---------------------------------------------------------------------------
   // Outputs decoded from the registered state
   // ---------------------------------------------------------------------------
   assign bus.hazir         = (durum == BOS);
   assign bus.buton_aktif   = (durum == BAS);
   assign bus.buton_giris   = (durum == BAS) ? kod_p1 : 8'h00;
   assign bus.kontrol_aktif = (durum == BAS) && kaydir_p1;
   assign bus.kontrol_giris = ((durum == BAS) && kaydir_p1) ? SHIFT_KODU : 8'h00;
   assign bus.hata          = hata_p1;

endmodule

// File: tb/tb_klavye_kodlayici.sv
// -----------------------------------------------------------------------------
// tb_klavye_kodlayici
//
// Directed bench for klavye_kodlayici. dut_a uses BASMA_SURE=1, BOSLUK_SURE=1;
// dut_b uses BASMA_SURE=3, BOSLUK_SURE=0 to cover multi-cycle holds and the
// direct return to idle. Honors KLAVYE_NUMPAD_EN for the keypad digit case.
// -----------------------------------------------------------------------------
module tb_klavye_kodlayici;

   logic clk = 1'b0;
   logic rst_n;

   int test_say = 0;
   int hata_say = 0;

   klavye_kodlayici_if bus_a ();
   klavye_kodlayici_if bus_b ();

   klavye_kodlayici #(.BASMA_SURE(1), .BOSLUK_SURE(1)) dut_a (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus_a)
   );

   klavye_kodlayici #(.BASMA_SURE(3), .BOSLUK_SURE(0)) dut_b (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus_b)
   );

   always #5 clk = ~clk;

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic kontrol(input string etiket, input logic [7:0] gozlenen,
                          input logic [7:0] beklenen);
      test_say++;
      assert (gozlenen === beklenen)
      else begin
         hata_say++;
         $error("FAIL %s: observed=%02h expected=%02h", etiket, gozlenen, beklenen);
      end
   endtask

   task automatic bak_a(input string t, input logic ba, input logic [7:0] bg,
                        input logic ka, input logic [7:0] kg,
                        input logic hz, input logic ht);
      kontrol({t, ".a.buton_aktif"},   8'(bus_a.buton_aktif),   8'(ba));
      kontrol({t, ".a.buton_giris"},   bus_a.buton_giris,       bg);
      kontrol({t, ".a.kontrol_aktif"}, 8'(bus_a.kontrol_aktif), 8'(ka));
      kontrol({t, ".a.kontrol_giris"}, bus_a.kontrol_giris,     kg);
      kontrol({t, ".a.hazir"},         8'(bus_a.hazir),         8'(hz));
      kontrol({t, ".a.hata"},          8'(bus_a.hata),          8'(ht));
   endtask

   task automatic bak_b(input string t, input logic ba, input logic [7:0] bg,
                        input logic ka, input logic [7:0] kg,
                        input logic hz, input logic ht);
      kontrol({t, ".b.buton_aktif"},   8'(bus_b.buton_aktif),   8'(ba));
      kontrol({t, ".b.buton_giris"},   bus_b.buton_giris,       bg);
      kontrol({t, ".b.kontrol_aktif"}, 8'(bus_b.kontrol_aktif), 8'(ka));
      kontrol({t, ".b.kontrol_giris"}, bus_b.kontrol_giris,     kg);
      kontrol({t, ".b.hazir"},         8'(bus_b.hazir),         8'(hz));
      kontrol({t, ".b.hata"},          8'(bus_b.hata),          8'(ht));
   endtask

   // Handshake one character on dut_a; returns just after the handshake edge.
   task automatic gonder_a(input logic [7:0] c, input logic caps, input logic num);
      bus_a.ascii_giris = c;
      bus_a.caps_lock   = caps;
      bus_a.num_lock    = num;
      bus_a.ascii_aktif = 1'b1;
      tick();
      bus_a.ascii_aktif = 1'b0;
   endtask

   task automatic gonder_b(input logic [7:0] c, input logic caps, input logic num);
      bus_b.ascii_giris = c;
      bus_b.caps_lock   = caps;
      bus_b.num_lock    = num;
      bus_b.ascii_aktif = 1'b1;
      tick();
      bus_b.ascii_aktif = 1'b0;
   endtask

   // Full supported press on dut_a: press cycle, idle cycle, back to ready.
   task automatic bas_a(input string t, input logic [7:0] c, input logic caps,
                        input logic [7:0] beklenen_kod, input logic shift);
      gonder_a(c, caps, 1'b0);
      bak_a({t, ".bas"}, 1'b1, beklenen_kod, shift, shift ? 8'h12 : 8'h00, 1'b0, 1'b0);
      tick();
      bak_a({t, ".birak"}, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0);
      tick();
      bak_a({t, ".bos"}, 1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 1'b0);
   endtask

   // Unsupported character on dut_a: one hata pulse, never leaves ready.
   task automatic desteksiz_a(input string t, input logic [7:0] c);
      gonder_a(c, 1'b0, 1'b0);
      bak_a({t, ".darbe"}, 1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 1'b1);
      tick();
      bak_a({t, ".sonra"}, 1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 1'b0);
   endtask

   logic [7:0] yedi_num;

   initial begin
      rst_n = 1'b0;
      bus_a.ascii_aktif = 1'b0; bus_a.ascii_giris = 8'h00;
      bus_a.caps_lock   = 1'b0; bus_a.num_lock    = 1'b0;
      bus_b.ascii_aktif = 1'b0; bus_b.ascii_giris = 8'h00;
      bus_b.caps_lock   = 1'b0; bus_b.num_lock    = 1'b0;
`ifdef KLAVYE_NUMPAD_EN
      yedi_num = 8'h6C;
`else
      yedi_num = 8'h3D;
`endif

      // Reset state
      tick();
      tick();
      bak_a("reset", 1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 1'b0);
      bak_b("reset", 1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 1'b0);
      rst_n = 1'b1;
      tick();

      // 't', caps off: 0x2C, no shift; idle; ready again
      bas_a("t", 8'h74, 1'b0, 8'h2C, 1'b0);

      // Shift rule
      bas_a("O_caps0", 8'h4F, 1'b0, 8'h44, 1'b1);
      bas_a("O_caps1", 8'h4F, 1'b1, 8'h44, 1'b0);
      bas_a("b_caps1", 8'h62, 1'b1, 8'h32, 1'b1);
      bas_a("a_caps0", 8'h61, 1'b0, 8'h1C, 1'b0);
      bas_a("Z_caps0", 8'h5A, 1'b0, 8'h1A, 1'b1);
      bas_a("z_caps0", 8'h7A, 1'b0, 8'h1A, 1'b0);

      // Digits and specials never shift, even with caps lock on
      bas_a("9_caps1", 8'h39, 1'b1, 8'h46, 1'b0);
      bas_a("space",   8'h20, 1'b0, 8'h29, 1'b0);
      bas_a("enter",   8'h0D, 1'b0, 8'h5A, 1'b0);
      bas_a("tab",     8'h09, 1'b0, 8'h0D, 1'b0);

      // Back-to-back "0;" with ascii_aktif held high
      bus_a.caps_lock   = 1'b0;
      bus_a.num_lock    = 1'b0;
      bus_a.ascii_giris = 8'h30;
      bus_a.ascii_aktif = 1'b1;
      tick();
      bus_a.ascii_giris = 8'h3B;   // presented while busy, must wait
      bak_a("b2b.0.bas", 1'b1, 8'h45, 1'b0, 8'h00, 1'b0, 1'b0);
      tick();
      bak_a("b2b.0.birak", 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0);
      tick();
      bak_a("b2b.bos", 1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 1'b0);
      tick();
      bus_a.ascii_aktif = 1'b0;
      bak_a("b2b.semi.bas", 1'b1, 8'h4C, 1'b0, 8'h00, 1'b0, 1'b0);
      tick();
      bak_a("b2b.semi.birak", 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0);
      tick();
      bak_a("b2b.son", 1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 1'b0);

      // Unsupported characters, including range edges
      desteksiz_a("at",   8'h40);
      desteksiz_a("lbr",  8'h5B);
      desteksiz_a("btk",  8'h60);
      desteksiz_a("x80",  8'h80);

      // dut_b: '7' with num_lock=1, held 3 cycles, then straight to ready
      gonder_b(8'h37, 1'b0, 1'b1);
      bak_b("7n1.c1", 1'b1, yedi_num, 1'b0, 8'h00, 1'b0, 1'b0);
      tick();
      bak_b("7n1.c2", 1'b1, yedi_num, 1'b0, 8'h00, 1'b0, 1'b0);
      tick();
      bak_b("7n1.c3", 1'b1, yedi_num, 1'b0, 8'h00, 1'b0, 1'b0);
      tick();
      bak_b("7n1.bos", 1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 1'b0);

      // '7' with num_lock=0: main row
      gonder_b(8'h37, 1'b0, 1'b0);
      bak_b("7n0.c1", 1'b1, 8'h3D, 1'b0, 8'h00, 1'b0, 1'b0);
      tick();
      tick();
      bak_b("7n0.c3", 1'b1, 8'h3D, 1'b0, 8'h00, 1'b0, 1'b0);
      tick();
      bak_b("7n0.bos", 1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 1'b0);

      // 'A' caps off, caps toggled mid-press must not matter
      gonder_b(8'h41, 1'b0, 1'b0);
      bus_b.caps_lock = 1'b1;
      bak_b("A.c1", 1'b1, 8'h1C, 1'b1, 8'h12, 1'b0, 1'b0);
      tick();
      bak_b("A.c2", 1'b1, 8'h1C, 1'b1, 8'h12, 1'b0, 1'b0);
      tick();
      bak_b("A.c3", 1'b1, 8'h1C, 1'b1, 8'h12, 1'b0, 1'b0);
      tick();
      bak_b("A.bos", 1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 1'b0);

      // Reset for 2 cycles in the middle of a press on dut_b
      gonder_b(8'h6B, 1'b0, 1'b0);
      bak_b("k.c1", 1'b1, 8'h42, 1'b0, 8'h00, 1'b0, 1'b0);
      rst_n = 1'b0;
      tick();
      tick();
      bak_b("rst_mid", 1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 1'b0);
      bak_a("rst_mid", 1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 1'b0);
      rst_n = 1'b1;
      tick();
      bak_b("rst_sonra", 1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 1'b0);

      // Press still works after the abort
      gonder_b(8'h20, 1'b0, 1'b0);
      bak_b("space.b", 1'b1, 8'h29, 1'b0, 8'h00, 1'b0, 1'b0);
      tick();
      tick();
      tick();
      bak_b("space.b.bos", 1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 1'b0);

      $display("[TB] %0d tests run, %0d failed", test_say, hata_say);
      $finish;
   end

endmodule
